// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: registers bank read data with EX/MEM/WB forwarding applied,
// detects load-use hazards and hands a held operand bundle to execute via valid/ready.
module operand_fetch_stage #(
    parameter int bus    = 32,
    parameter int dir    = 4,
    parameter int ctrl_w = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [dir-1:0]    RS,
    input  logic [dir-1:0]    RX,
    input  logic [dir-1:0]    RK,
    input  logic [dir-1:0]    RD,
    input  logic [3:0]        in_use,
    input  logic [bus-1:0]    RSd,
    input  logic [bus-1:0]    RXd,
    input  logic [bus-1:0]    RKd,
    input  logic [bus-1:0]    StrReg,
    input  logic [ctrl_w-1:0] in_ctrl,
    input  logic              ex_we,
    input  logic              mem_we,
    input  logic              wb_we,
    input  logic [dir-1:0]    ex_rd,
    input  logic [dir-1:0]    mem_rd,
    input  logic [dir-1:0]    wb_rd,
    input  logic [bus-1:0]    ex_data,
    input  logic [bus-1:0]    mem_data,
    input  logic [bus-1:0]    wb_data,
    input  logic              ex_load,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [bus-1:0]    op_s,
    output logic [bus-1:0]    op_x,
    output logic [bus-1:0]    op_k,
    output logic [bus-1:0]    op_st,
    output logic [dir-1:0]    out_rd,
    output logic [ctrl_w-1:0] out_ctrl,
    output logic              hazard,
    output logic [15:0]       stall_cnt
);
    localparam logic [dir-1:0] PC_ADDR = dir'(15);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state_q;
    logic [bus-1:0]    op_s_q, op_x_q, op_k_q, op_st_q;
    logic [dir-1:0]    out_rd_q;
    logic [ctrl_w-1:0] out_ctrl_q;
    logic [15:0]       stall_cnt_q;

    logic              advance;
    logic              src_hit;
    logic [bus-1:0]    fwd_s_d, fwd_x_d, fwd_k_d, fwd_st_d;

    // The PC is never a forwarding target; a pending load in EX has no data yet.
    function automatic logic [bus-1:0] resolve(
        input logic [dir-1:0] src,
        input logic [bus-1:0] bank,
        input logic           ex_ok,
        input logic           mem_ok,
        input logic           wb_ok
    );
        logic [bus-1:0] val;
        val = bank;
        if (src != PC_ADDR) begin
            if (ex_ok && ex_rd == src)         val = ex_data;
            else if (mem_ok && mem_rd == src)  val = mem_data;
            else if (wb_ok && wb_rd == src)    val = wb_data;
        end
        return val;
    endfunction

    always_comb begin
        fwd_s_d  = resolve(RS, RSd,    ex_we && !ex_load, mem_we, wb_we);
        fwd_x_d  = resolve(RX, RXd,    ex_we && !ex_load, mem_we, wb_we);
        fwd_k_d  = resolve(RK, RKd,    ex_we && !ex_load, mem_we, wb_we);
        fwd_st_d = resolve(RD, StrReg, ex_we && !ex_load, mem_we, wb_we);
    end

    assign src_hit = (in_use[0] && RS == ex_rd) || (in_use[1] && RX == ex_rd) ||
                     (in_use[2] && RK == ex_rd) || (in_use[3] && RD == ex_rd);
    assign hazard   = in_valid && ex_load && ex_we && (ex_rd != PC_ADDR) && src_hit;
    assign advance  = (state_q == EMPTY) || out_ready;
    assign in_ready = advance && !hazard && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            op_s_q      <= '0;
            op_x_q      <= '0;
            op_k_q      <= '0;
            op_st_q     <= '0;
            out_rd_q    <= '0;
            out_ctrl_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (hazard && !flush && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;

            if (flush) begin
                state_q <= EMPTY;
            end else if (advance) begin
                if (in_valid && !hazard) begin
                    state_q    <= FULL;
                    op_s_q     <= fwd_s_d;
                    op_x_q     <= fwd_x_d;
                    op_k_q     <= fwd_k_d;
                    op_st_q    <= fwd_st_d;
                    out_rd_q   <= RD;
                    out_ctrl_q <= in_ctrl;
                end else begin
                    state_q <= EMPTY;
                end
            end
        end
    end

    assign out_valid = (state_q == FULL);
    assign op_s      = op_s_q;
    assign op_x      = op_x_q;
    assign op_k      = op_k_q;
    assign op_st     = op_st_q;
    assign out_rd    = out_rd_q;
    assign out_ctrl  = out_ctrl_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus randomized
// traffic compared against a behavioural forwarding/hazard model.
module tb_operand_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready;
    logic [3:0]  RS, RX, RK, RD, in_use;
    logic [31:0] RSd, RXd, RKd, StrReg;
    logic [7:0]  in_ctrl;
    logic        ex_we, mem_we, wb_we, ex_load, flush;
    logic [3:0]  ex_rd, mem_rd, wb_rd;
    logic [31:0] ex_data, mem_data, wb_data;
    logic        out_valid, out_ready, hazard;
    logic [31:0] op_s, op_x, op_k, op_st;
    logic [3:0]  out_rd;
    logic [7:0]  out_ctrl;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_valid;
    logic [31:0] m_ops[4];
    logic [3:0]  m_rd, m_use;
    logic [7:0]  m_ctrl;
    int          m_cnt;

    always #5 clk = ~clk;

    operand_fetch_stage #(.bus(32), .dir(4), .ctrl_w(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .RS(RS), .RX(RX), .RK(RK), .RD(RD), .in_use(in_use),
        .RSd(RSd), .RXd(RXd), .RKd(RKd), .StrReg(StrReg), .in_ctrl(in_ctrl),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_data(ex_data), .mem_data(mem_data), .wb_data(wb_data),
        .ex_load(ex_load), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_s(op_s), .op_x(op_x), .op_k(op_k), .op_st(op_st),
        .out_rd(out_rd), .out_ctrl(out_ctrl),
        .hazard(hazard), .stall_cnt(stall_cnt)
    );

    // Writers listed youngest first; the first one that targets src wins.
    function automatic logic [31:0] ref_operand(input logic [3:0] src, input logic [31:0] bank);
        logic        we[3];
        logic [3:0]  rd[3];
        logic [31:0] dat[3];
        we[0] = ex_we && !ex_load; rd[0] = ex_rd;  dat[0] = ex_data;
        we[1] = mem_we;            rd[1] = mem_rd; dat[1] = mem_data;
        we[2] = wb_we;             rd[2] = wb_rd;  dat[2] = wb_data;
        if (src == 4'd15) return bank;
        for (int i = 0; i < 3; i++)
            if (we[i] && rd[i] == src) return dat[i];
        return bank;
    endfunction

    function automatic bit ref_hazard();
        logic [3:0] srcs[4];
        srcs[0] = RS; srcs[1] = RX; srcs[2] = RK; srcs[3] = RD;
        if (!(in_valid && ex_load && ex_we) || ex_rd == 4'd15) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (in_use[i] && srcs[i] == ex_rd) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit haz, adv;
        haz = ref_hazard();
        adv = !m_valid || out_ready;
        if (haz && !flush && m_cnt < 65535) m_cnt++;
        if (flush) begin
            m_valid = 1'b0;
        end else if (adv && in_valid && !haz) begin
            m_valid  = 1'b1;
            m_ops[0] = ref_operand(RS, RSd);
            m_ops[1] = ref_operand(RX, RXd);
            m_ops[2] = ref_operand(RK, RKd);
            m_ops[3] = ref_operand(RD, StrReg);
            m_rd     = RD;
            m_ctrl   = in_ctrl;
            m_use    = in_use;
        end else if (adv) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic idle();
        in_valid = 0; RS = 0; RX = 0; RK = 0; RD = 0; in_use = 0;
        RSd = 0; RXd = 0; RKd = 0; StrReg = 0; in_ctrl = 0;
        ex_we = 0; mem_we = 0; wb_we = 0; ex_load = 0; flush = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_data = 0; mem_data = 0; wb_data = 0;
        out_ready = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        m_valid = 0; m_cnt = 0; m_use = 0; m_rd = 0; m_ctrl = 0;
        for (int i = 0; i < 4; i++) m_ops[i] = '0;
    endtask

    function automatic logic [3:0] pick_addr();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r + 3);
    endfunction

    task automatic test_reset();
        idle();
        rst_n = 0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (op_s !== 32'h0) begin bad++; $display("FAIL reset_op_s got=%h exp=0", op_s); end
        total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", stall_cnt); end
        total++; if (out_ctrl !== 8'h0 || out_rd !== 4'h0) begin bad++; $display("FAIL reset_pass got=%h/%h exp=0/0", out_ctrl, out_rd); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_passthrough();
        do_reset();
        RS = 2; RSd = 32'hA; RX = 3; RXd = 32'hB; RD = 7; in_use = 4'b0011;
        in_ctrl = 8'h5A; in_valid = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pass_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pass_valid got=%b exp=1", out_valid); end
        total++; if (op_s !== 32'hA) begin bad++; $display("FAIL pass_op_s got=%h exp=a", op_s); end
        total++; if (op_x !== 32'hB) begin bad++; $display("FAIL pass_op_x got=%h exp=b", op_x); end
        total++; if (out_rd !== 4'd7 || out_ctrl !== 8'h5A) begin bad++; $display("FAIL pass_rd_ctrl got=%h/%h exp=7/5a", out_rd, out_ctrl); end
    endtask

    task automatic test_forward_priority();
        logic        t_ex_we[3];
        logic [3:0]  t_addr[3];
        logic [31:0] t_exp[3];
        t_ex_we[0] = 1; t_addr[0] = 5;  t_exp[0] = 32'h111;
        t_ex_we[1] = 0; t_addr[1] = 5;  t_exp[1] = 32'h222;
        t_ex_we[2] = 1; t_addr[2] = 15; t_exp[2] = 32'hABC;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            RS = t_addr[c]; RSd = 32'hABC; in_use = 4'b0001; in_valid = 1;
            ex_we = t_ex_we[c]; mem_we = 1; wb_we = 1;
            ex_rd = t_addr[c]; mem_rd = t_addr[c]; wb_rd = t_addr[c];
            ex_data = 32'h111; mem_data = 32'h222; wb_data = 32'h333;
            @(posedge clk); #1;
            total++; if (op_s !== t_exp[c]) begin bad++; $display("FAIL fwd_case%0d got=%h exp=%h", c, op_s, t_exp[c]); end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_load = 1; ex_we = 1; ex_rd = 4; RX = 4; RXd = 32'hDEAD; in_use = 4'b0010; in_valid = 1;
        #1;
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL lu_hazard got=%b exp=1", hazard); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b exp=0", out_valid); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        @(negedge clk);
        ex_load = 0; ex_we = 0; mem_we = 1; mem_rd = 4; mem_data = 32'h77;
        #1;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL lu_clear got=%b exp=0", hazard); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || op_x !== 32'h77) begin bad++; $display("FAIL lu_fwd got=%b/%h exp=1/77", out_valid, op_x); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt_hold got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        RS = 1; RSd = 32'h100; in_use = 4'b0001; RD = 2; in_ctrl = 8'h11; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0; RSd = 32'h200; RD = 3; in_ctrl = 8'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%b exp=0", i, in_ready); end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || op_s !== 32'h100 || out_ctrl !== 8'h11 || out_rd !== 4'd2)
                begin bad++; $display("FAIL bp_hold%0d got=%b/%h/%h/%h exp=1/100/11/2", i, out_valid, op_s, out_ctrl, out_rd); end
            @(negedge clk);
        end
        out_ready = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        total++; if (op_s !== 32'h200 || out_ctrl !== 8'h22 || out_rd !== 4'd3)
            begin bad++; $display("FAIL bp_next got=%h/%h/%h exp=200/22/3", op_s, out_ctrl, out_rd); end
    endtask

    task automatic test_flush();
        do_reset();
        RS = 1; RSd = 32'h1234; in_use = 4'b0001; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0; RSd = 32'h999; flush = 1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        // Hazard under flush must not count
        @(negedge clk);
        out_ready = 1; ex_load = 1; ex_we = 1; ex_rd = 1;
        @(posedge clk); #1;
        total++; if (stall_cnt !== 16'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_cnt got=%0d/%b exp=0/0", stall_cnt, out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        RS = 1; RSd = 32'h1234; in_use = 4'b0001; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0; ex_load = 1; ex_we = 1; ex_rd = 1;
        @(posedge clk); #1;
        total++; if (op_s !== 32'h1234 || stall_cnt !== 16'd1) begin bad++; $display("FAIL rm_pre got=%h/%0d exp=1234/1", op_s, stall_cnt); end
        @(negedge clk);
        rst_n = 0;
        #1;
        total++; if (out_valid !== 1'b0 || op_s !== 32'h0 || stall_cnt !== 16'h0)
            begin bad++; $display("FAIL rm_async got=%b/%h/%h exp=0/0/0", out_valid, op_s, stall_cnt); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_saturation();
        do_reset();
        ex_load = 1; ex_we = 1; ex_rd = 9; RK = 9; in_use = 4'b0100; in_valid = 1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", stall_cnt); end
        repeat (6) @(posedge clk);
        @(negedge clk);
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_final got=%h exp=ffff", stall_cnt); end
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL sat_hazard got=%b exp=1", hazard); end
    endtask

    task automatic test_random();
        bit exp_haz, exp_rdy;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            ex_load   = ($urandom_range(0, 2) == 0);
            ex_we = $urandom_range(0, 1); mem_we = $urandom_range(0, 1); wb_we = $urandom_range(0, 1);
            RS = pick_addr(); RX = pick_addr(); RK = pick_addr(); RD = pick_addr();
            ex_rd = pick_addr(); mem_rd = pick_addr(); wb_rd = pick_addr();
            in_use = 4'($urandom_range(0, 15));
            RSd = $urandom; RXd = $urandom; RKd = $urandom; StrReg = $urandom;
            ex_data = $urandom; mem_data = $urandom; wb_data = $urandom;
            in_ctrl = 8'($urandom);
            #1;
            exp_haz = ref_hazard();
            exp_rdy = (!m_valid || out_ready) && !exp_haz && !flush;
            total++; if (hazard !== exp_haz || in_ready !== exp_rdy)
                begin bad++; $display("FAIL rnd_comb%0d got=%b/%b exp=%b/%b", n, hazard, in_ready, exp_haz, exp_rdy); end
            @(posedge clk);
            model_edge();
            #1;
            total++; if (out_valid !== m_valid || stall_cnt !== 16'(m_cnt))
                begin bad++; $display("FAIL rnd_state%0d got=%b/%0d exp=%b/%0d", n, out_valid, stall_cnt, m_valid, m_cnt); end
            if (m_valid) begin
                total++; if ((m_use[0] && op_s !== m_ops[0]) || (m_use[1] && op_x !== m_ops[1]) ||
                             (m_use[2] && op_k !== m_ops[2]) || (m_use[3] && op_st !== m_ops[3]) ||
                             out_rd !== m_rd || out_ctrl !== m_ctrl)
                    begin bad++; $display("FAIL rnd_ops%0d got=%h %h %h %h rd=%h c=%h exp=%h %h %h %h rd=%h c=%h use=%b",
                        n, op_s, op_x, op_k, op_st, out_rd, out_ctrl,
                        m_ops[0], m_ops[1], m_ops[2], m_ops[3], m_rd, m_ctrl, m_use); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_forward_priority();
        test_load_use();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Pipeline stage directly downstream of the register bank.
- Captures the registered read data (RSd, RXd, RKd, StrReg) with the decoded addresses and control word.
- Overrides stale operands with in-flight results from EX/MEM/WB (forwarding) and detects load-use hazards.
- Presents a held operand bundle to the execute stage through a valid/ready handshake, with flush support.

Parameters:
- bus, 32, data width of registers and operands
- dir, 4, register address width (2**dir registers; register 15 is PC)
- ctrl_w, 8, width of opaque decoded control word passed through

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode bundle valid; register bank read data is valid this cycle
- in_ready  out  1  stage accepts bundle this cycle
- RS, RX, RK, RD  in  dir each  source/destination addresses matching the bank read data
- in_use  in  4  source-used mask: [0]RS [1]RX [2]RK [3]RD-as-store-source
- RSd, RXd, RKd, StrReg  in  bus each  register bank read data
- in_ctrl  in  ctrl_w  decoded control word
- ex_we, mem_we, wb_we  in  1 each  stage will write a register
- ex_rd, mem_rd, wb_rd  in  dir each  destination of each stage
- ex_data, mem_data, wb_data  in  bus each  result of each stage (ex_data ignored when ex_load=1)
- ex_load  in  1  EX instruction is a load (data not yet available)
- flush  in  1  kill held and incoming bundle
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute stage accepts bundle
- op_s, op_x, op_k, op_st  out  bus each  resolved operands
- out_rd  out  dir  destination passthrough
- out_ctrl  out  ctrl_w  control passthrough
- hazard  out  1  load-use stall active this cycle (combinational)
- stall_cnt  out  16  saturating count of hazard cycles

Behaviour:
- Reset (async, rst_n=0): out_valid=0, op_*=0, out_rd=0, out_ctrl=0, stall_cnt=0. Internal state to EMPTY. Deassertion is released synchronously to clk by the integrator.
- State: EMPTY (out_valid=0), FULL (out_valid=1).
- advance = !out_valid || out_ready.
- hazard = in_valid && ex_load && ex_we && ex_rd != 15 && ex_rd matches any source selected by in_use (RD compared only when in_use[3]).
- in_ready = advance && !hazard && !flush.
- Forwarding per operand, evaluated combinationally on the cycle of capture. Priority: EX (only if !ex_load) > MEM > WB > bank data.
  - A stage matches when its we=1 and its rd equals the source address.
  - Address 15 is never forwarded; bank data is used.
  - Unused sources (in_use bit 0) are still resolved the same way; their value is don't-care for checking.
- Transitions on posedge:
  - flush=1: out_valid<=0 (→EMPTY), regardless of out_ready or in_valid; bundle dropped; stall_cnt unchanged.
  - else advance && in_valid && !hazard: capture resolved operands, RD, in_ctrl; out_valid<=1 (→FULL).
  - else advance (no input, or hazard): out_valid<=0; a bubble is inserted on hazard.
  - else (FULL, out_ready=0): hold all outputs unchanged.
- stall_cnt increments each cycle hazard=1 && !flush, saturating at 0xFFFF.
- Latency: one cycle from accepted input to out_valid. Throughput: one bundle per cycle with no hazard.
- A hazard lasts while EX holds the load; upstream must hold RS/RX/RK/RD/data stable while in_ready=0.
- Outputs are stable while out_valid && !out_ready; forwarded values are not re-evaluated during hold.

Test Plan:
- Reset mid-operation: FULL with op_s=0x1234, assert rst_n=0 between edges -> out_valid=0, op_s=0, stall_cnt=0 immediately.
- Plain pass-through: RS=2 RSd=0xA, RX=3 RXd=0xB, no writers, in_valid=1 -> next cycle out_valid=1, op_s=0xA, op_x=0xB.
- Forward priority: RS=5, ex_we/mem_we/wb_we=1 with rd=5, data 0x111/0x222/0x333 -> op_s=0x111. Same with ex_we=0 -> 0x222. RS=15, all rd=15 -> bank value.
- Load-use: ex_load=1 ex_we=1 ex_rd=4, RX=4, in_use[1]=1 -> hazard=1, in_ready=0, bubble out, stall_cnt=1. Next cycle ex_load=0, mem_rd=4 mem_data=0x77 -> op_x=0x77.
- Back-pressure: FULL, out_ready=0 for 3 cycles, new in_valid -> in_ready=0, outputs unchanged. out_ready=1 -> new bundle captured the next edge.
- Flush priority: FULL, out_ready=0, in_valid=1, flush=1 -> out_valid=0 next edge, input not captured. Saturation: force 65540 hazard cycles -> stall_cnt=0xFFFF.
